cpu_trace_buffer: RTL and testbench

Circular trace recorder that sits directly downstream of the CPU core and consumes its debug outputs (pc, x3, x31). Each time the program counter changes it stores one 96-bit entry {x31, x3, pc}. An optional PC-match trigger freezes the buffer a programmable number of entries after the trigger. The debug VIO reads the frozen history back through an index port, so the buffer holds far more history than the ILA window alone.

---
 rtl/cpu_trace_buffer.sv | 110 +++++++++++
 tb/tb_cpu_trace_buffer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/cpu_trace_buffer.sv
// rtl/cpu_trace_buffer.sv - circular {x31, x3, pc} trace recorder with PC-match freeze
module cpu_trace_buffer #(
  parameter int DEPTH_LOG2 = 5,
  parameter int POST_TRIG  = 16
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic [31:0]           pc_i,
  input  logic [31:0]           x3_i,
  input  logic [31:0]           x31_i,
  input  logic                  arm_i,
  input  logic                  trig_en_i,
  input  logic [31:0]           trig_pc_i,
  input  logic [DEPTH_LOG2-1:0] rd_addr_i,
  output logic [95:0]           rd_data_o,
  output logic [1:0]            state_o,
  output logic [DEPTH_LOG2:0]   count_o,
  output logic [DEPTH_LOG2-1:0] wr_ptr_o,
  output logic [DEPTH_LOG2-1:0] trig_ptr_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   DEPTH_CNT = DEPTH[DEPTH_LOG2:0];
  localparam logic [DEPTH_LOG2-1:0] POST_INIT = POST_TRIG[DEPTH_LOG2-1:0];

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    POST  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                state;
  logic [31:0]           last_pc;
  logic                  last_pc_valid;
  logic [DEPTH_LOG2-1:0] post_cnt;
  logic [95:0]           mem [DEPTH];

  logic                  capturing;
  logic                  cap;
  logic                  arm_clear;
  logic                  trig_hit;
  logic                  do_write;
  logic [DEPTH_LOG2-1:0] oldest;
  logic [DEPTH_LOG2-1:0] phys;

  assign capturing = (state == ARMED) || (state == POST);
  assign cap       = capturing && (!last_pc_valid || (pc_i != last_pc));
  assign arm_clear = arm_i && (state != ARMED);
  assign trig_hit  = (state == ARMED) && trig_en_i && (pc_i == trig_pc_i);
  // arm wins over a capture in the same cycle
  assign do_write  = cap && !arm_clear;

  assign oldest = (count_o == DEPTH_CNT) ? wr_ptr_o : '0;
  assign phys   = oldest + rd_addr_i;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state         <= IDLE;
      count_o       <= '0;
      wr_ptr_o      <= '0;
      trig_ptr_o    <= '0;
      post_cnt      <= '0;
      last_pc_valid <= 1'b0;
      last_pc       <= '0;
    end else if (arm_clear) begin
      state         <= ARMED;
      count_o       <= '0;
      wr_ptr_o      <= '0;
      last_pc_valid <= 1'b0;
    end else if (do_write) begin
      wr_ptr_o      <= wr_ptr_o + 1'b1;
      last_pc       <= pc_i;
      last_pc_valid <= 1'b1;
      if (count_o != DEPTH_CNT) begin
        count_o <= count_o + 1'b1;
      end
      if (trig_hit) begin
        trig_ptr_o <= wr_ptr_o;
        post_cnt   <= POST_INIT;
        state      <= (POST_TRIG == 0) ? DONE : POST;
      end else if (state == POST) begin
        post_cnt <= post_cnt - 1'b1;
        if (post_cnt == 1) begin
          state <= DONE;
        end
      end
    end
  end

  assign state_o = state;

  // storage is intentionally unreset; count masks stale slots
  always_ff @(posedge clk_i) begin
    if (do_write) begin
      mem[wr_ptr_o] <= {x31_i, x3_i, pc_i};
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rd_data_o <= '0;
    end else if ({1'b0, rd_addr_i} < count_o) begin
      rd_data_o <= mem[phys];
    end else begin
      rd_data_o <= '0;
    end
  end

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// tb/tb_cpu_trace_buffer.sv - directed self-checking bench for cpu_trace_buffer
module tb_cpu_trace_buffer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] pc = '0;
  logic [31:0] x3 = '0;
  logic [31:0] x31 = '0;
  logic        arm = 1'b0;
  logic        trig_en = 1'b0;
  logic [31:0] trig_pc = '0;
  logic [4:0]  rd_addr = '0;

  logic [95:0] rd_data, rd_data0;
  logic [1:0]  state, state0;
  logic [5:0]  count, count0;
  logic [4:0]  wr_ptr, wr_ptr0;
  logic [4:0]  trig_ptr, trig_ptr0;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  cpu_trace_buffer #(.DEPTH_LOG2(5), .POST_TRIG(16)) dut (
    .clk_i(clk), .reset_i(reset), .pc_i(pc), .x3_i(x3), .x31_i(x31),
    .arm_i(arm), .trig_en_i(trig_en), .trig_pc_i(trig_pc), .rd_addr_i(rd_addr),
    .rd_data_o(rd_data), .state_o(state), .count_o(count),
    .wr_ptr_o(wr_ptr), .trig_ptr_o(trig_ptr)
  );

  cpu_trace_buffer #(.DEPTH_LOG2(5), .POST_TRIG(0)) dut0 (
    .clk_i(clk), .reset_i(reset), .pc_i(pc), .x3_i(x3), .x31_i(x31),
    .arm_i(arm), .trig_en_i(trig_en), .trig_pc_i(trig_pc), .rd_addr_i(rd_addr),
    .rd_data_o(rd_data0), .state_o(state0), .count_o(count0),
    .wr_ptr_o(wr_ptr0), .trig_ptr_o(trig_ptr0)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_pc(input logic [31:0] v);
    pc  = v;
    x3  = v + 32'd1;
    x31 = ~v;
    step();
  endtask

  task automatic restart();
    reset = 1'b1;
    step();
    reset = 1'b0;
    arm = 1'b1;
    step();
    arm = 1'b0;
  endtask

  task automatic chk(input string name, input logic [95:0] got, input logic [95:0] exp);
    checks++;
    if (got !== exp) $display("FAIL %s: got %0h required %0h", name, got, exp);
    else passed++;
  endtask

  task automatic read_pc(input string name, input logic [4:0] a, input logic [31:0] exp);
    rd_addr = a;
    step();
    checks++;
    if (rd_data[31:0] !== exp) $display("FAIL %s: got %0h required %0h", name, rd_data[31:0], exp);
    else passed++;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    arm = 1'b1;
    step();
    arm = 1'b0;
    drive_pc(32'h100);
    drive_pc(32'h104);
    rd_addr = 5'd0;
    step();
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (state !== 2'd0) $display("FAIL reset_state: got %0d required 0", state); else passed++;
    checks++;
    if (count !== 6'd0) $display("FAIL reset_count: got %0d required 0", count); else passed++;
    checks++;
    if (wr_ptr !== 5'd0) $display("FAIL reset_wr_ptr: got %0d required 0", wr_ptr); else passed++;
    checks++;
    if (rd_data !== 96'd0) $display("FAIL reset_rd_data: got %0h required 0", rd_data); else passed++;
    checks++;
    if (trig_ptr !== 5'd0) $display("FAIL reset_trig_ptr: got %0d required 0", trig_ptr); else passed++;
    step();
  endtask

  task automatic test_duplicate();
    restart();
    drive_pc(32'h0);
    drive_pc(32'h4);
    drive_pc(32'h8);
    drive_pc(32'h8);
    drive_pc(32'h8);
    drive_pc(32'hC);
    chk("dup_count", {90'd0, count}, 96'd4);
    rd_addr = 5'd0;
    step();
    chk("dup_entry0_full", rd_data, {32'hFFFF_FFFF, 32'h1, 32'h0});
    read_pc("dup_rd1", 5'd1, 32'h4);
    read_pc("dup_rd2", 5'd2, 32'h8);
    read_pc("dup_rd3", 5'd3, 32'hC);
    rd_addr = 5'd4;
    step();
    chk("dup_rd4_zero", rd_data, 96'd0);
  endtask

  task automatic test_wrap();
    restart();
    for (int i = 0; i < 40; i++) drive_pc(32'(i * 4));
    chk("wrap_count", {90'd0, count}, 96'd32);
    chk("wrap_wr_ptr", {91'd0, wr_ptr}, 96'd8);
    read_pc("wrap_rd0", 5'd0, 32'h20);
    read_pc("wrap_rd31", 5'd31, 32'h9C);
    read_pc("wrap_rd10", 5'd10, 32'h48);
  endtask

  task automatic test_trigger();
    trig_en = 1'b1;
    trig_pc = 32'h40;
    restart();
    for (int i = 0; i < 16; i++) drive_pc(32'(i * 4));
    chk("trig_pre_state", {94'd0, state}, 96'd1);
    drive_pc(32'h40);
    chk("trig_state_post", {94'd0, state}, 96'd2);
    chk("trig_ptr", {91'd0, trig_ptr}, 96'd16);
    chk("trig_wr_ptr", {91'd0, wr_ptr}, 96'd17);
    for (int i = 17; i < 32; i++) drive_pc(32'(i * 4));
    chk("trig_still_post", {94'd0, state}, 96'd2);
    drive_pc(32'h80);
    chk("trig_done", {94'd0, state}, 96'd3);
    chk("trig_count_sat", {90'd0, count}, 96'd32);
    drive_pc(32'h84);
    drive_pc(32'h40);
    chk("trig_frozen_wr_ptr", {91'd0, wr_ptr}, 96'd1);
    chk("trig_frozen_state", {94'd0, state}, 96'd3);
    read_pc("trig_rd31", 5'd31, 32'h80);
    read_pc("trig_rd0", 5'd0, 32'h4);
    read_pc("trig_rd15", 5'd15, 32'h40);
    trig_en = 1'b0;
  endtask

  task automatic test_arm_priority();
    trig_en = 1'b1;
    trig_pc = 32'h8;
    restart();
    drive_pc(32'h0);
    drive_pc(32'h4);
    drive_pc(32'h8);
    chk("prio_in_post", {94'd0, state}, 96'd2);
    arm = 1'b1;
    drive_pc(32'hC);
    arm = 1'b0;
    chk("prio_state_armed", {94'd0, state}, 96'd1);
    chk("prio_count_zero", {90'd0, count}, 96'd0);
    chk("prio_wr_ptr_zero", {91'd0, wr_ptr}, 96'd0);
    trig_en = 1'b0;
    drive_pc(32'h10);
    chk("prio_count_after", {90'd0, count}, 96'd1);
    read_pc("prio_rd0", 5'd0, 32'h10);
  endtask

  task automatic test_post_trig0();
    trig_en = 1'b1;
    trig_pc = 32'h4;
    restart();
    drive_pc(32'h0);
    chk("pt0_armed", {94'd0, state0}, 96'd1);
    drive_pc(32'h4);
    chk("pt0_done", {94'd0, state0}, 96'd3);
    chk("pt0_trig_ptr", {91'd0, trig_ptr0}, 96'd1);
    drive_pc(32'h8);
    drive_pc(32'hC);
    chk("pt0_count", {90'd0, count0}, 96'd2);
    chk("pt0_wr_ptr", {91'd0, wr_ptr0}, 96'd2);
    rd_addr = 5'd1;
    step();
    chk("pt0_rd1", {64'd0, rd_data0[31:0]}, 96'h4);
    trig_en = 1'b0;
  endtask

  initial begin
    step();
    test_reset();
    test_duplicate();
    test_wrap();
    test_trigger();
    test_arm_priority();
    test_post_trig0();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
